// File: rtl/fp_divider_pkg.sv
// Shared types for the FP divider: rounding modes, divider FSM states, canonical NaN,
// the execute-stage side-band bus and a leading-zero counter for subnormal normalisation.
package fp_divider_pkg;

    localparam logic [31:0] FP_CANON_NAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rm_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        DIV   = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } fdiv_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd_addr;
        logic        rd_we;
        logic [2:0]  rob_tag;
    } exe_p_mux_bus_type;

    // Leading zeros of a 24-bit mantissa; 24 when the value is zero.
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        lzc24 = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) lzc24 = 5'(23 - i);
        end
    endfunction

endpackage

// File: rtl/fp_div_mant_iter.sv
// Restoring radix-2 mantissa divider: one quotient bit per i_step, 26-bit partial remainder.
module fp_div_mant_iter
    import fp_divider_pkg::*;
#(
    parameter int DIV_BITS = 27
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic                i_step,
    input  logic [23:0]         i_dividend,
    input  logic [23:0]         i_divisor,
    output logic [DIV_BITS-1:0] o_quot,
    output logic                o_rem_nz,
    output logic                o_last
);

    localparam int CW = $clog2(DIV_BITS);

    logic [25:0]         r_rem;
    logic [23:0]         r_div;
    logic [DIV_BITS-1:0] r_quot;
    logic [CW-1:0]       r_cnt;

    logic [26:0] w_diff;
    logic        w_ge;
    logic [25:0] w_rem_nxt;

    // Remainder stays below twice the divisor, so the shifted value always fits in 26 bits.
    assign w_diff    = {1'b0, r_rem} - {3'b000, r_div};
    assign w_ge      = ~w_diff[26];
    assign w_rem_nxt = w_ge ? w_diff[25:0] : r_rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem  <= '0;
            r_div  <= '0;
            r_quot <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_rem  <= {2'b00, i_dividend};
            r_div  <= i_divisor;
            r_quot <= '0;
            r_cnt  <= '0;
        end else if (i_step) begin
            r_rem  <= w_rem_nxt << 1;
            r_quot <= {r_quot[DIV_BITS-2:0], w_ge};
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign o_quot   = r_quot;
    assign o_rem_nz = |r_rem;
    assign o_last   = (r_cnt == CW'(DIV_BITS - 1));

endmodule

// File: rtl/fp_divider.sv
// Iterative binary32 divider (fdiv.s): classify/normalise, restoring divide, round, report.
// Define FP_DIV_FFLAGS_EN to build the exception-flag logic; otherwise fflags is tied to zero.
module fp_divider
    import fp_divider_pkg::*;
#(
    parameter int DIV_BITS = 27
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              kill,
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    input  logic [2:0]        rm,
    input  exe_p_mux_bus_type fdiv_pipeline_signals_i,
    output logic              busy,
    output logic              done,
    output logic [31:0]       result,
    output exe_p_mux_bus_type fdiv_pipeline_signals_o,
    output logic [4:0]        fflags,
    output fdiv_state_e       o_dbg_state
);

    fdiv_state_e       r_state, w_state_nxt;
    logic [31:0]       r_a, r_b, r_result;
    logic [2:0]        r_rm;
    exe_p_mux_bus_type r_sb;
    logic              r_sign;
    logic signed [9:0] r_exp;

    logic [7:0]        w_ea, w_eb;
    logic [22:0]       w_fa, w_fb;
    logic              w_a_zero, w_a_sub, w_a_inf, w_a_nan;
    logic              w_b_zero, w_b_sub, w_b_inf, w_b_nan;
    logic [4:0]        w_lz_a, w_lz_b;
    logic [23:0]       w_ma, w_mb;
    logic signed [9:0] w_ea_eff, w_eb_eff, w_e_div;
    logic              w_sgn, w_nan_case, w_special, w_accept, w_load, w_step;
    logic [31:0]       w_spec_res;

    logic [DIV_BITS-1:0] w_q;
    logic                w_rem_nz, w_last;

    assign w_ea     = r_a[30:23];
    assign w_fa     = r_a[22:0];
    assign w_eb     = r_b[30:23];
    assign w_fb     = r_b[22:0];
    assign w_a_zero = (w_ea == 8'h00) && (w_fa == '0);
    assign w_a_sub  = (w_ea == 8'h00) && (w_fa != '0);
    assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == '0);
    assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != '0);
    assign w_b_zero = (w_eb == 8'h00) && (w_fb == '0);
    assign w_b_sub  = (w_eb == 8'h00) && (w_fb != '0);
    assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == '0);
    assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != '0);
    assign w_sgn    = r_a[31] ^ r_b[31];

    // Subnormals are shifted into [1,2); their biased exponent becomes 1 - lz.
    assign w_lz_a   = lzc24({1'b0, w_fa});
    assign w_lz_b   = lzc24({1'b0, w_fb});
    assign w_ma     = w_a_sub ? ({1'b0, w_fa} << w_lz_a) : {1'b1, w_fa};
    assign w_mb     = w_b_sub ? ({1'b0, w_fb} << w_lz_b) : {1'b1, w_fb};
    assign w_ea_eff = w_a_sub ? (10'sd1 - $signed({5'b0, w_lz_a})) : $signed({2'b00, w_ea});
    assign w_eb_eff = w_b_sub ? (10'sd1 - $signed({5'b0, w_lz_b})) : $signed({2'b00, w_eb});
    assign w_e_div  = w_ea_eff - w_eb_eff + 10'sd127;

    assign w_nan_case = w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf);

    always_comb begin
        w_special  = 1'b1;
        w_spec_res = {w_sgn, 31'h0};
        if (w_nan_case)               w_spec_res = FP_CANON_NAN;
        else if (w_a_inf)             w_spec_res = {w_sgn, 31'h7F800000};
        else if (w_b_zero)            w_spec_res = {w_sgn, 31'h7F800000};
        else if (w_a_zero || w_b_inf) w_spec_res = {w_sgn, 31'h0};
        else                          w_special  = 1'b0;
    end

    // ---------------- control FSM ----------------
    assign w_accept = (r_state == IDLE) && start && !kill;
    assign w_load   = (r_state == PREP) && !w_special && !kill;
    assign w_step   = (r_state == DIV) && !kill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = PREP;
            PREP:    w_state_nxt = w_special ? DONE : DIV;
            DIV:     if (w_last) w_state_nxt = ROUND;
            ROUND:   w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (kill) w_state_nxt = IDLE;
    end

    assign busy        = (r_state != IDLE);
    assign done        = (r_state == DONE);
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_rm   <= '0;
            r_sb   <= '0;
            r_sign <= 1'b0;
            r_exp  <= '0;
        end else begin
            if (kill) begin
                r_sb <= '0;
            end else if (w_accept) begin
                r_a  <= a;
                r_b  <= b;
                r_rm <= rm;
                r_sb <= fdiv_pipeline_signals_i;
            end
            if (r_state == PREP) begin
                r_sign <= w_sgn;
                r_exp  <= w_e_div;
            end
        end
    end

    fp_div_mant_iter #(.DIV_BITS(DIV_BITS)) u_iter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_dividend (w_ma),
        .i_divisor  (w_mb),
        .o_quot     (w_q),
        .o_rem_nz   (w_rem_nz),
        .o_last     (w_last)
    );

    // ---------------- normalise / denormalise / round ----------------
    logic signed [9:0] w_e_n, w_sh;
    logic [22:0]       w_n_mant, w_f_mant;
    logic              w_n_g, w_n_r, w_n_s, w_f_g, w_f_r, w_f_s;
    logic [25:0]       w_v;
    logic [24:0]       w_v_sh;
    logic              w_lost, w_inc, w_ovf;
    logic [7:0]        w_exp_f;
    logic [30:0]       w_pre, w_rnd;
    logic [31:0]       w_ovf_res, w_rnd_res;

    always_comb begin
        w_e_n    = r_exp;
        w_n_mant = w_q[25:3];
        w_n_g    = w_q[2];
        w_n_r    = w_q[1];
        w_n_s    = w_q[0] | w_rem_nz;
        if (!w_q[26]) begin
            w_e_n    = r_exp - 10'sd1;
            w_n_mant = w_q[24:2];
            w_n_g    = w_q[1];
            w_n_r    = w_q[0];
            w_n_s    = w_rem_nz;
        end
    end

    assign w_sh   = 10'sd1 - w_e_n;
    assign w_v    = {1'b1, w_n_mant, w_n_g, w_n_r};
    assign w_v_sh = 25'(w_v >> w_sh[4:0]);
    assign w_lost = |(w_v & ~({26{1'b1}} << w_sh[4:0]));

    // Tiny results are shifted right so the hidden bit lands in the fraction; lost bits go sticky.
    always_comb begin
        w_exp_f  = w_e_n[7:0];
        w_f_mant = w_n_mant;
        w_f_g    = w_n_g;
        w_f_r    = w_n_r;
        w_f_s    = w_n_s;
        if (w_e_n <= 10'sd0) begin
            w_exp_f = 8'd0;
            if (w_sh >= 10'sd26) begin
                w_f_mant = '0;
                w_f_g    = 1'b0;
                w_f_r    = 1'b0;
                w_f_s    = 1'b1;
            end else begin
                w_f_mant = w_v_sh[24:2];
                w_f_g    = w_v_sh[1];
                w_f_r    = w_v_sh[0];
                w_f_s    = w_n_s | w_lost;
            end
        end
    end

    always_comb begin
        w_inc = 1'b0;
        case (r_rm)
            RTZ:     w_inc = 1'b0;
            RDN:     w_inc = r_sign & (w_f_g | w_f_r | w_f_s);
            RUP:     w_inc = ~r_sign & (w_f_g | w_f_r | w_f_s);
            RMM:     w_inc = w_f_g;
            default: w_inc = w_f_g & (w_f_r | w_f_s | w_f_mant[0]);
        endcase
    end

    // Mantissa carry ripples into the exponent field, including subnormal -> exponent 1.
    assign w_pre = {w_exp_f, w_f_mant};
    assign w_rnd = w_pre + {30'b0, w_inc};
    assign w_ovf = (w_e_n >= 10'sd255) || (w_rnd[30:23] == 8'hFF);

    always_comb begin
        case (r_rm)
            RTZ:     w_ovf_res = {r_sign, 31'h7F7FFFFF};
            RUP:     w_ovf_res = r_sign ? 32'hFF7FFFFF : 32'h7F800000;
            RDN:     w_ovf_res = r_sign ? 32'hFF800000 : 32'h7F7FFFFF;
            default: w_ovf_res = {r_sign, 31'h7F800000};
        endcase
    end

    assign w_rnd_res = w_ovf ? w_ovf_res : {r_sign, w_rnd};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        r_result <= '0;
        else if (!kill && (r_state == PREP) && w_special)  r_result <= w_spec_res;
        else if (!kill && (r_state == ROUND))              r_result <= w_rnd_res;
    end

    assign result                  = r_result;
    assign fdiv_pipeline_signals_o = r_sb;

`ifdef FP_DIV_FFLAGS_EN
    logic [4:0] r_fflags, w_spec_flags, w_rnd_flags;
    logic       w_a_snan, w_b_snan, w_nx;

    assign w_a_snan = w_a_nan & ~w_fa[22];
    assign w_b_snan = w_b_nan & ~w_fb[22];

    // Tininess is judged on the rounded result: exponent field still zero.
    always_comb begin
        w_spec_flags = 5'b0;
        if (w_nan_case)
            w_spec_flags[4] = w_a_snan | w_b_snan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
        else if (!w_a_inf && w_b_zero)
            w_spec_flags[3] = 1'b1;
        w_nx        = w_f_g | w_f_r | w_f_s | w_ovf;
        w_rnd_flags = {2'b00, w_ovf, ~w_ovf & (w_rnd[30:23] == 8'd0) & w_nx, w_nx};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        r_fflags <= '0;
        else if (!kill && (r_state == PREP) && w_special)  r_fflags <= w_spec_flags;
        else if (!kill && (r_state == ROUND))              r_fflags <= w_rnd_flags;
    end

    assign fflags = r_fflags;
`else
    assign fflags = 5'b0;
`endif

endmodule
